// File: rtl/normalize_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | normalize_seq : iterative FP-add significand normalizer feeding the rounder  |
// | Optional NORM_COARSE_SHIFT_EN: 4-bit left steps when the top nibble is zero. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module normalize_seq #(
   parameter int WSIG = 23,
   parameter int WEXP = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WSIG+1:0] sum,
   input  logic            guard_in,
   input  logic            round_in,
   input  logic            sticky_in,
   input  logic [WEXP-1:0] exp_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WSIG-1:0] normsum,
   output logic            round,
   output logic            sticky,
   output logic [WEXP-1:0] overexp,
   output logic            zero,
   output logic            denorm
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_shift = 2'd1;
   localparam logic [1:0] c_done  = 2'd2;

   localparam logic [WEXP-1:0] c_one = WEXP'(1);

   logic [1:0]      r_state;
   logic [WSIG:0]   r_sig;
   logic            r_g;
   logic            r_r;
   logic            r_s;
   logic [WEXP-1:0] r_e;

   logic            r_out_valid;
   logic [WSIG-1:0] r_normsum;
   logic            r_round;
   logic            r_sticky;
   logic [WEXP-1:0] r_overexp;
   logic            r_zero;
   logic            r_denorm;

   logic            w_coarse;
   logic            w_step;
   logic            w_stop;
   logic [WSIG:0]   w_sig;
   logic            w_g;
   logic            w_r;
   logic [WEXP-1:0] w_e;

   function automatic logic [WEXP-1:0] dec_sat(input logic [WEXP-1:0] v);
      return (v == '0) ? '0 : v - c_one;
   endfunction

`ifdef NORM_COARSE_SHIFT_EN
   localparam logic [WEXP-1:0] c_four = WEXP'(4);
   assign w_coarse = (r_sig[WSIG:WSIG-3] == 4'b0000) && (r_e > c_four);
`else
   assign w_coarse = 1'b0;
`endif

   assign w_step = !r_sig[WSIG] && (r_e > c_one);

   // Candidate next value of the shift window {sig, guard, round}; the
   // termination test below looks at this value so the last step and the
   // result capture share one cycle.
   always_comb begin
      w_sig = r_sig;
      w_g   = r_g;
      w_r   = r_r;
      w_e   = r_e;
      if (w_coarse) begin
`ifdef NORM_COARSE_SHIFT_EN
         w_sig = {r_sig[WSIG-4:0], r_g, r_r, 2'b00};
         w_e   = r_e - c_four;
`endif
         w_g   = 1'b0;
         w_r   = 1'b0;
      end else if (w_step) begin
         w_sig = {r_sig[WSIG-1:0], r_g};
         w_g   = r_r;
         w_r   = 1'b0;
         w_e   = r_e - c_one;
      end
   end

   assign w_stop = w_sig[WSIG] || (w_e <= c_one);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_idle;
         r_sig       <= '0;
         r_g         <= 1'b0;
         r_r         <= 1'b0;
         r_s         <= 1'b0;
         r_e         <= '0;
         r_out_valid <= 1'b0;
         r_normsum   <= '0;
         r_round     <= 1'b0;
         r_sticky    <= 1'b0;
         r_overexp   <= '0;
         r_zero      <= 1'b0;
         r_denorm    <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (in_valid) begin
                  r_sig    <= sum[WSIG:0];
                  r_g      <= guard_in;
                  r_r      <= round_in;
                  r_s      <= sticky_in;
                  r_e      <= exp_in;
                  r_zero   <= 1'b0;
                  r_denorm <= 1'b0;
                  if (sum[WSIG+1]) begin
                     r_normsum   <= sum[WSIG:1];
                     r_round     <= sum[0];
                     r_sticky    <= guard_in | round_in | sticky_in;
                     r_overexp   <= exp_in;
                     r_out_valid <= 1'b1;
                     r_state     <= c_done;
                  end else if ((sum == '0) && !guard_in && !round_in) begin
                     r_zero      <= 1'b1;
                     r_normsum   <= '0;
                     r_round     <= 1'b0;
                     r_sticky    <= sticky_in;
                     r_overexp   <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= c_done;
                  end else if (sum[WSIG]) begin
                     r_normsum   <= sum[WSIG-1:0];
                     r_round     <= guard_in;
                     r_sticky    <= round_in | sticky_in;
                     r_overexp   <= dec_sat(exp_in);
                     r_out_valid <= 1'b1;
                     r_state     <= c_done;
                  end else begin
                     r_state     <= c_shift;
                  end
               end
            end
            c_shift: begin
               r_sig <= w_sig;
               r_g   <= w_g;
               r_r   <= w_r;
               r_e   <= w_e;
               if (w_stop) begin
                  r_normsum   <= w_sig[WSIG-1:0];
                  r_round     <= w_g;
                  r_sticky    <= w_r | r_s;
                  r_overexp   <= dec_sat(w_e);
                  r_denorm    <= !w_sig[WSIG];
                  r_out_valid <= 1'b1;
                  r_state     <= c_done;
               end
            end
            c_done: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= c_idle;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign in_ready  = (r_state == c_idle);
   assign out_valid = r_out_valid;
   assign normsum   = r_normsum;
   assign round     = r_round;
   assign sticky    = r_sticky;
   assign overexp   = r_overexp;
   assign zero      = r_zero;
   assign denorm    = r_denorm;

endmodule
`default_nettype wire

// File: tb/tb_normalize_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_normalize_seq : directed + random bench for normalize_seq (WSIG=23/WEXP=8)|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_normalize_seq;

   localparam int WSIG = 23;
   localparam int WEXP = 8;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [WSIG+1:0] sum;
   logic            guard_in;
   logic            round_in;
   logic            sticky_in;
   logic [WEXP-1:0] exp_in;
   logic            out_valid;
   logic            out_ready;
   logic [WSIG-1:0] normsum;
   logic            round;
   logic            sticky;
   logic [WEXP-1:0] overexp;
   logic            zero;
   logic            denorm;

   int n_cmp = 0;
   int n_err = 0;

   normalize_seq #(.WSIG(WSIG), .WEXP(WEXP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .guard_in(guard_in), .round_in(round_in), .sticky_in(sticky_in),
      .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
      .normsum(normsum), .round(round), .sticky(sticky), .overexp(overexp),
      .zero(zero), .denorm(denorm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WSIG-1:0] ns;
      logic            rnd;
      logic            stk;
      logic [WEXP-1:0] oe;
      logic            z;
      logic            dn;
      int              lat;
   } exp_t;

   // Value view: the window {sum[hidden:0], guard, round} is moved left by as
   // many places as its leading-zero count allows, limited by the exponent floor.
   function automatic exp_t model(input logic [WSIG+1:0] s, input logic g, input logic r,
                                  input logic st, input logic [WEXP-1:0] e);
      exp_t m;
      logic [WSIG+2:0] v;
      logic [WSIG+2:0] v2;
      int d, k, en, c, dr, ee;
      m.z = 1'b0; m.dn = 1'b0; m.lat = 1;
      m.ns = '0; m.rnd = 1'b0; m.stk = 1'b0; m.oe = '0;
      if (s[WSIG+1]) begin
         m.ns = s[WSIG:1]; m.rnd = s[0]; m.stk = g | r | st; m.oe = e;
      end else if ((s == '0) && !g && !r) begin
         m.z = 1'b1; m.stk = st;
      end else begin
         v = {s[WSIG:0], g, r};
         d = WSIG + 3;
         for (int i = 0; i <= WSIG + 2; i++) if (v[i]) d = WSIG + 2 - i;
         k = (int'(e) > 1) ? int'(e) - 1 : 0;
         if (d < k) k = d;
         v2 = v << k;
         en = int'(e) - k;
         m.ns  = v2[WSIG+1:2];
         m.rnd = v2[1];
         m.stk = v2[0] | st;
         m.oe  = (en > 0) ? WEXP'(en - 1) : '0;
         m.dn  = (k < d);
         if (d > 0) begin
            c = k;
`ifdef NORM_COARSE_SHIFT_EN
            c = 0; dr = d; ee = int'(e);
            while (dr > 0 && ee > 1) begin
               if (dr >= 4 && ee > 4) begin dr -= 4; ee -= 4; end
               else begin dr -= 1; ee -= 1; end
               c++;
            end
`else
            dr = 0; ee = 0;
`endif
            m.lat = ((c < 1) ? 1 : c) + 1;
         end
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic run_op(input string tag, input logic [WSIG+1:0] s, input logic g,
                         input logic r, input logic st, input logic [WEXP-1:0] e,
                         input int hold, input bit junk, output int lat);
      exp_t m;
      m = model(s, g, r, st, e);
      sum = s; guard_in = g; round_in = r; sticky_in = st; exp_in = e;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = junk;
      if (junk) begin sum = ~s; exp_in = ~e; guard_in = ~g; end
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      chk({tag, ".valid"},   32'(out_valid), 32'd1);
      chk({tag, ".normsum"}, 32'(normsum),   32'(m.ns));
      chk({tag, ".round"},   32'(round),     32'(m.rnd));
      chk({tag, ".sticky"},  32'(sticky),    32'(m.stk));
      chk({tag, ".overexp"}, 32'(overexp),   32'(m.oe));
      chk({tag, ".zero"},    32'(zero),      32'(m.z));
      chk({tag, ".denorm"},  32'(denorm),    32'(m.dn));
      chk({tag, ".latency"}, 32'(lat),       32'(m.lat));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".hold_ns"},    32'(normsum),   32'(m.ns));
         chk({tag, ".hold_oe"},    32'(overexp),   32'(m.oe));
         chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".drop"},  32'(out_valid), 32'd0);
      chk({tag, ".ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int want_lat;
      bit saw;
      logic [31:0] rnd;
      logic [31:0] rnd2;
      logic [WSIG+1:0] rs;
      logic [WEXP-1:0] re;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      sum = '0; guard_in = 1'b0; round_in = 1'b0; sticky_in = 1'b0; exp_in = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst.in_ready",  32'(in_ready),  32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.normsum",   32'(normsum),   32'd0);
      chk("rst.overexp",   32'(overexp),   32'd0);
      chk("rst.flags",     32'({round, sticky, zero, denorm}), 32'd0);

      run_op("carry", 25'h1800000, 1'b1, 1'b0, 1'b0, 8'd100, 0, 1'b0, lat);
      chk("carry.plan_ns",  32'(normsum), 32'h400000);
      chk("carry.plan_lat", 32'(lat), 32'd1);

      run_op("norm", 25'h0800001, 1'b1, 1'b0, 1'b0, 8'd127, 0, 1'b0, lat);
      chk("norm.plan_oe",  32'(overexp), 32'd126);
      chk("norm.plan_lat", 32'(lat), 32'd1);

      run_op("lshift", 25'h0100000, 1'b1, 1'b0, 1'b0, 8'd127, 0, 1'b0, lat);
      chk("lshift.plan_ns",  32'(normsum), 32'h000004);
      chk("lshift.plan_oe",  32'(overexp), 32'd123);
      chk("lshift.plan_lat", 32'(lat), 32'd4);

      run_op("coarse", 25'h0000100, 1'b0, 1'b0, 1'b0, 8'd127, 0, 1'b0, lat);
`ifdef NORM_COARSE_SHIFT_EN
      want_lat = 7;
`else
      want_lat = 16;
`endif
      chk("coarse.plan_oe",  32'(overexp), 32'd111);
      chk("coarse.plan_lat", 32'(lat), 32'(want_lat));

      run_op("denorm", 25'h0000001, 1'b0, 1'b0, 1'b0, 8'd3, 0, 1'b0, lat);
      chk("denorm.plan_ns",  32'(normsum), 32'h000004);
      chk("denorm.plan_dn",  32'(denorm), 32'd1);
      chk("denorm.plan_lat", 32'(lat), 32'd3);

      run_op("zero", 25'h0, 1'b0, 1'b0, 1'b1, 8'd50, 0, 1'b0, lat);
      chk("zero.plan_z",   32'(zero), 32'd1);
      chk("zero.plan_lat", 32'(lat), 32'd1);

      // zero flag must clear on the following accept
      run_op("after_zero", 25'h0C00000, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, lat);
      run_op("floor_e0", 25'h0400000, 1'b1, 1'b1, 1'b0, 8'd0, 0, 1'b0, lat);
      run_op("floor_e1", 25'h0000003, 1'b0, 1'b1, 1'b1, 8'd1, 0, 1'b0, lat);
      run_op("guard_only", 25'h0, 1'b1, 1'b0, 1'b0, 8'd200, 0, 1'b0, lat);
      run_op("hit_at_e1", 25'h0200000, 1'b0, 1'b0, 1'b0, 8'd3, 0, 1'b0, lat);
      run_op("bp_junk", 25'h0100000, 1'b1, 1'b1, 1'b0, 8'd127, 5, 1'b1, lat);

      sum = 25'h0000100; exp_in = 8'd127; guard_in = 1'b0; round_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid.busy", 32'(in_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid.valid",   32'(out_valid), 32'd0);
      chk("rst_mid.ready",   32'(in_ready),  32'd1);
      chk("rst_mid.normsum", 32'(normsum),   32'd0);
      saw = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("rst_mid.no_pulse", 32'(saw), 32'd0);

      for (int n = 0; n < 150; n++) begin
         rnd = $urandom;
         rs = rnd[WSIG+1:0];
         rs = rs >> $urandom_range(0, WSIG + 2);
         rnd2 = $urandom;
         re = (rnd2[31:30] == 2'b00) ? WEXP'(rnd2[2:0]) : rnd2[WEXP-1:0];
         run_op("rand", rs, rnd2[8], rnd2[9], rnd2[10], re,
                int'(rnd2[13:12]), rnd2[14], lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/normalize_seq.md
# normalize_seq

Multi-cycle normalizer for the FP adder datapath, directly upstream of the rounding stage. Takes the raw significand sum from the adder with guard/round/sticky bits and the pre-normalization exponent. Produces the normalized fraction (hidden bit stripped), round bit, sticky bit and pre-rounding exponent in exactly the form the rounder consumes, where the final exponent is overexp+1, or overexp+2 on rounding overflow. Operates iteratively under a valid/ready handshake so wide cancellations do not need a full barrel shifter.

## Interface
- `WSIG`, from constants.v: fraction width, without hidden bit.
- `WEXP`, from constants.v: exponent width.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept; equals (state==IDLE).
- sum  input  `WSIG+2  raw sum; [`WSIG+1]=carry-out, [`WSIG]=hidden-bit position, [`WSIG-1:0]=fraction.
- guard_in, round_in, sticky_in  input  1 each  bits below sum LSB, in that order.
- exp_in  input  `WEXP  exponent of the larger operand.
- out_valid  output  1  result registers valid.
- out_ready  input  1  rounder accepts result.
- normsum  output  `WSIG  normalized fraction, no leading 1.
- round  output  1  round bit for rounder.
- sticky  output  1  sticky bit for rounder.
- overexp  output  `WEXP  exponent such that final = overexp+1 (no round overflow).
- zero  output  1  result is exact zero.
- denorm  output  1  left shift stopped by exponent floor; hidden bit is 0.

## Operation
- States: IDLE, SHIFT, DONE. All outputs registered.
- Accept occurs when in_valid & in_ready. Capture sum, guard, round, sticky and e=exp_in. Then classify:
  - **Carry** (sum[`WSIG+1]=1). normsum=sum[`WSIG:1], round=sum[0], sticky=guard_in|round_in|sticky_in, overexp=exp_in. Go to DONE.
  - **Zero** (sum==0, guard_in==0, round_in==0). zero=1, normsum=0, round=0, sticky=sticky_in, overexp=0. Go to DONE.
  - **Normalized** (sum[`WSIG]=1). normsum=sum[`WSIG-1:0], round=guard_in, sticky=round_in|sticky_in, overexp=exp_in-1. Go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, one step per cycle:
  - If hidden=0 and e>1, do one step: {sum,guard,round} <<= 1 with 0 shifted into round, and e=e-1.
  - When hidden=1, output as in the Normalized case using current e. Go to DONE.
  - When hidden=0 and e<=1, output the same way with denorm=1 and overexp = (e==0) ? 0 : e-1. Go to DONE.
- DONE: out_valid=1; outputs held stable while out_ready=0. When out_ready=1, go to IDLE. out_valid drops the next cycle; zero and denorm clear at the next accept.
- Exponent arithmetic is unsigned `WEXP bits, saturating at 0, never wrapping.

## Timing
- Reset: state=IDLE; out_valid, normsum, round, sticky, overexp, zero and denorm all 0; in_ready=1 in the cycle after reset.
- Latency from accept edge to out_valid:
  - 1 cycle for Carry, Zero and Normalized.
  - 1+k cycles for k shift cycles.
- Throughput: one operation in flight; in_ready=0 from accept until the DONE handshake completes.
- Reset asserted mid-SHIFT or in DONE aborts the operation. The result is discarded with no out_valid pulse.
- in_valid while busy is ignored; upstream must hold its data.

## Configuration
- NORM_COARSE_SHIFT_EN defined: in SHIFT, if sum[`WSIG:`WSIG-3]==0 and e>4, shift 4 bits per cycle, shifting in guard, round, 0, 0 and setting e=e-4. Otherwise shift 1 bit.
- NORM_COARSE_SHIFT_EN undefined: always 1 bit per cycle.
- Results are bit-identical in both builds; only latency differs.

## Test plan
All scenarios use `WSIG=23, `WEXP=8.
- Carry: sum=25'h1800000, exp_in=100, guard=1 -> normsum=23'h400000, round=0, sticky=1, overexp=100, out_valid 1 cycle after accept.
- Normalized: sum=25'h0800001, exp_in=127, guard=1, round=0, sticky=0 -> normsum=23'h000001, round=1, sticky=0, overexp=126, latency 1.
- Left shift: sum=25'h0100000, exp_in=127, guard=1 -> normsum=23'h000004, round=0, sticky=0, overexp=123, latency 4.
- Coarse shift: sum=25'h0000100, exp_in=127 -> normsum=0, overexp=111. Latency 16 without NORM_COARSE_SHIFT_EN, 7 with it.
- Denorm and zero:
  - sum=25'h0000001, exp_in=3 -> normsum=23'h000004, denorm=1, overexp=0, latency 3.
  - sum=0 with guard=round=0 -> zero=1, overexp=0, latency 1.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Assert reset mid-SHIFT -> no out_valid, in_ready=1 next cycle.
